selftest_runner: RTL and testbench



---
 rtl/selftest_pkg.sv | 17 +
 rtl/blink_code.sv | 56 +++++
 rtl/selftest_runner.sv | 155 +++++++++++++++
 tb/tb_selftest_runner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/selftest_pkg.sv
// Shared definitions for the self-test sequencer: FSM encoding and blink-code timing.
package selftest_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LAUNCH = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_NEXT   = 3'd3;
    localparam state_t S_PASS   = 3'd4;
    localparam state_t S_FAIL   = 3'd5;

    // Dark gap between blink-code repetitions, in phases.
    localparam int unsigned BLINK_GAP   = 4;
    localparam int unsigned BLINK_GAP_W = $clog2(BLINK_GAP);

endpackage

// File: rtl/blink_code.sv
// Red LED blink-code generator: (i_count+1) on/off pulses, then a dark gap, repeating.
module blink_code
    import selftest_pkg::*;
#(
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned BLINK_W = 22
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_count,
    output logic             o_led
);

    logic [BLINK_W-1:0]     r_presc;
    logic [BLINK_GAP_W-1:0] r_phase;
    logic [IDX_W:0]         r_pulse;
    logic                   w_tick;
    logic                   w_in_gap;

    assign w_tick   = &r_presc;
    // r_pulse runs past the last pulse index while the gap is being counted.
    assign w_in_gap = r_pulse > {1'b0, i_count};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_phase <= '0;
            r_pulse <= '0;
        end else if (!i_en) begin
            r_presc <= '0;
            r_phase <= '0;
            r_pulse <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_tick) begin
                if (w_in_gap) begin
                    if (r_phase == BLINK_GAP_W'(BLINK_GAP - 1)) begin
                        r_phase <= '0;
                        r_pulse <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end else if (r_phase[0]) begin
                    r_phase <= '0;
                    r_pulse <= r_pulse + 1'b1;
                end else begin
                    r_phase <= BLINK_GAP_W'(1);
                end
            end
        end
    end

    assign o_led = i_en & ~w_in_gap & ~r_phase[0];

endmodule

// File: rtl/selftest_runner.sv
// Runs the attached test fixtures in index order with a per-test timeout and
// reports the aggregate verdict on status outputs and the RGB LED.
module selftest_runner
    import selftest_pkg::*;
#(
    parameter int unsigned N_TESTS   = 4,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned BLINK_W   = 22
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [N_TESTS-1:0] i_running,
    input  logic [N_TESTS-1:0] i_passed,
    output logic [N_TESTS-1:0] o_run,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic               o_timeout,
    output logic [IDX_W-1:0]   o_fail_idx,
    output logic               o_led_r,
    output logic               o_led_g,
    output logic               o_led_b
);

    state_t                r_state;
    state_t                w_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_fail_idx;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic [TIMEOUT_W-1:0]  w_cnt_inc;
    logic                  r_start_q;
    logic                  r_start_edge;
    logic                  r_timeout;
    logic [N_TESTS-1:0]    w_sel;
    logic                  w_running;
    logic                  w_passed;
    logic                  w_last;
    logic                  w_cnt_sat;
    logic                  w_idle_like;
    logic                  w_begin;

    assign w_sel       = N_TESTS'(1) << r_idx;
    assign w_running   = |(i_running & w_sel);
    assign w_passed    = |(i_passed & w_sel);
    assign w_last      = (r_idx == IDX_W'(N_TESTS - 1));
    assign w_cnt_inc   = r_cnt + 1'b1;
    // Saturation is judged on the incremented value so WAIT lasts 2^TIMEOUT_W-1 cycles.
    assign w_cnt_sat   = &w_cnt_inc;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_PASS) || (r_state == S_FAIL);
    assign w_begin     = r_start_edge && w_idle_like;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (r_start_edge) w_next = S_LAUNCH;
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (!w_running) begin
                    w_next = w_passed ? S_NEXT : S_FAIL;
                end else if (w_cnt_sat) begin
                    w_next = S_FAIL;
                end
            end
            S_NEXT:  w_next = w_last ? S_PASS : S_LAUNCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_q    <= 1'b0;
            r_start_edge <= 1'b0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_fail_idx   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_start_q    <= i_start;
            r_start_edge <= i_start & ~r_start_q;
            if (w_begin) begin
                r_idx      <= '0;
                r_fail_idx <= '0;
                r_timeout  <= 1'b0;
            end
            case (r_state)
                S_LAUNCH: r_cnt <= '0;
                S_WAIT: begin
                    if (!(&r_cnt)) r_cnt <= w_cnt_inc;
                    if (w_next == S_FAIL) begin
                        r_fail_idx <= r_idx;
                        r_timeout  <= w_running;
                    end
                end
                S_NEXT: begin
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_run   = '0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_pass  = 1'b0;
        o_led_g = 1'b0;
        o_led_b = 1'b0;
        case (r_state)
            S_LAUNCH, S_WAIT: begin
                o_run   = w_sel;
                o_busy  = 1'b1;
                o_led_b = 1'b1;
            end
            S_NEXT: begin
                o_busy  = 1'b1;
                o_led_b = 1'b1;
            end
            S_PASS: begin
                o_done  = 1'b1;
                o_pass  = 1'b1;
                o_led_g = 1'b1;
            end
            S_FAIL:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_timeout  = r_timeout;
    assign o_fail_idx = r_fail_idx;

    blink_code #(
        .IDX_W   (IDX_W),
        .BLINK_W (BLINK_W)
    ) u_blink (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_state == S_FAIL),
        .i_count (r_fail_idx),
        .o_led   (o_led_r)
    );

endmodule

// File: tb/tb_selftest_runner.sv
// Bench for selftest_runner: behavioural fixture models plus an outcome/timing reference model.
module tb_selftest_runner;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int TW = 4;
    localparam int BW = 2;
    localparam int T  = (1 << TW) - 1;
    localparam int PH = 1 << BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  running = '0;
    logic [N-1:0]  passed = '0;
    logic [N-1:0]  run;
    logic          busy, done, pass, tmo;
    logic [IW-1:0] fidx;
    logic          led_r, led_g, led_b;

    int n_checks = 0;
    int n_errors = 0;

    int dur[N];
    bit verd[N];
    bit cfg_apply = 1'b0;
    int k[N];

    int         busy_total = 0;
    int         launch_n = 0;
    int         run_bad = 0;
    logic [N-1:0] launch_log[256];
    logic [N-1:0] prev_run = '0;

    always #5 clk = ~clk;

    selftest_runner #(
        .N_TESTS   (N),
        .IDX_W     (IW),
        .TIMEOUT_W (TW),
        .BLINK_W   (BW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_running  (running),
        .i_passed   (passed),
        .o_run      (run),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
        .o_timeout  (tmo),
        .o_fail_idx (fidx),
        .o_led_r    (led_r),
        .o_led_g    (led_g),
        .o_led_b    (led_b)
    );

    // Fixture i keeps running high for dur[i] WAIT cycles, then reports verd[i].
    // dur[i]==0 models a fixture that is already stopped with its verdict held.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cfg_apply) begin
                running[i] <= 1'b0;
                passed[i]  <= (dur[i] == 0) ? verd[i] : 1'b0;
                k[i]       <= 0;
            end else if (run[i]) begin
                if (k[i] == 0) begin
                    if (dur[i] > 0) begin
                        running[i] <= 1'b1;
                        passed[i]  <= 1'b0;
                    end
                end else if (k[i] > dur[i]) begin
                    running[i] <= 1'b0;
                    passed[i]  <= verd[i];
                end
                k[i] <= k[i] + 1;
            end else begin
                k[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (busy) busy_total <= busy_total + 1;
        if (!$onehot0(run)) run_bad <= run_bad + 1;
        if (run != '0 && prev_run == '0) begin
            launch_log[launch_n[7:0]] <= run;
            launch_n <= launch_n + 1;
        end
        prev_run <= run;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_cfg();
        @(posedge clk);
        cfg_apply = 1'b1;
        @(posedge clk);
        cfg_apply = 1'b0;
    endtask

    task automatic run_scn(input string name, input int hold, input bit extra_edge);
        int exp_fail, exp_busy, exp_nl, b0, l0, r0, c, mism, ph, pos;
        bit exp_tmo, e;
        exp_fail = -1;
        exp_tmo  = 1'b0;
        exp_busy = 0;
        exp_nl   = 0;
        // Reference: LAUNCH + (d+1) WAIT + NEXT per passing test; timeout after T WAIT cycles.
        for (int i = 0; i < N; i++) begin
            exp_nl++;
            if (dur[i] >= T) begin
                exp_busy += 1 + T;
                exp_fail = i;
                exp_tmo  = 1'b1;
                break;
            end
            exp_busy += dur[i] + 2;
            if (!verd[i]) begin
                exp_fail = i;
                break;
            end
            exp_busy += 1;
        end

        apply_cfg();
        b0 = busy_total;
        l0 = launch_n;
        r0 = run_bad;
        @(negedge clk);
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk({name, "/busy_seen"}, busy, 1);
        chk({name, "/done_clr"}, done, 0);
        if (extra_edge) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        c = 0;
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk({name, "/done"}, done, 1);
        chk({name, "/busy"}, busy, 0);
        chk({name, "/pass"}, pass, (exp_fail < 0));
        chk({name, "/timeout"}, tmo, exp_tmo);
        if (exp_fail >= 0) chk({name, "/fail_idx"}, fidx, exp_fail);
        chk({name, "/run_zero"}, run, 0);
        chk({name, "/led_g"}, led_g, (exp_fail < 0));
        chk({name, "/led_b"}, led_b, 0);
        chk({name, "/busy_cycles"}, busy_total - b0, exp_busy);
        chk({name, "/launches"}, launch_n - l0, exp_nl);
        for (int j = 0; j < exp_nl; j++)
            chk($sformatf("%s/launch%0d", name, j), launch_log[(l0 + j) % 256], 1 << j);
        chk({name, "/onehot"}, run_bad - r0, 0);
        if (exp_fail >= 0) begin
            mism = 0;
            for (int t = 0; t < 80; t++) begin
                ph  = t / PH;
                pos = ph % (2 * (exp_fail + 1) + 4);
                e   = (pos < 2 * (exp_fail + 1)) && (pos % 2 == 0);
                if (led_r !== e) mism++;
                @(negedge clk);
            end
            chk({name, "/blink"}, mism, 0);
        end else begin
            chk({name, "/led_r"}, led_r, 0);
        end
        repeat (5) @(negedge clk);
        chk({name, "/done_hold"}, done, 1);
        chk({name, "/no_relaunch"}, launch_n - l0, exp_nl);
    endtask

    initial begin
        int c, l0;
        for (int i = 0; i < N; i++) begin
            dur[i]  = 1;
            verd[i] = 1'b1;
        end
        apply_cfg();
        repeat (2) @(negedge clk);
        chk("rst/run", run, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/pass", pass, 0);
        chk("rst/timeout", tmo, 0);
        chk("rst/fail_idx", fidx, 0);
        chk("rst/leds", {led_r, led_g, led_b}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle/busy", busy, 0);

        dur  = '{5, 2, 0, 7};
        verd = '{1, 1, 1, 1};
        run_scn("all_pass", 2, 1'b0);

        dur  = '{3, 1, 4, 2};
        verd = '{1, 1, 0, 1};
        run_scn("fail2", 2, 1'b0);

        dur  = '{2, 1000, 1, 1};
        verd = '{1, 1, 1, 1};
        run_scn("timeout1", 2, 1'b0);

        dur  = '{T - 1, 1, 1, 1};
        verd = '{1, 1, 1, 1};
        run_scn("verdict_vs_sat", 2, 1'b0);

        dur  = '{1, 1, 1, 1};
        run_scn("hold10_extra", 10, 1'b1);
        run_scn("restart_after_pass", 2, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                dur[i]  = int'($urandom_range(0, 17));
                verd[i] = ($urandom_range(0, 5) != 0);
            end
            run_scn($sformatf("rand%0d", r), int'($urandom_range(1, 4)), 1'b0);
        end

        dur  = '{3, 10, 3, 3};
        verd = '{1, 1, 1, 1};
        apply_cfg();
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        c = 0;
        while (run != 4'b0010 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("rstmid/reach_test1", run, 4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid/run", run, 0);
        chk("rstmid/busy", busy, 0);
        chk("rstmid/done", done, 0);
        chk("rstmid/leds", {led_r, led_g, led_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        l0 = launch_n;
        repeat (20) @(negedge clk);
        chk("rstmid/idle_busy", busy, 0);
        chk("rstmid/idle_done", done, 0);
        chk("rstmid/no_launch", launch_n - l0, 0);

        dur  = '{2, 0, 3, 1};
        verd = '{1, 1, 1, 0};
        run_scn("after_reset", 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
